// File: rtl/ins_issue_read_if.sv
// ---------------------------------------------------------------------------
// ins_issue_read_if
//   Bundles the handshake and status signals of the instruction-queue
//   read/retire block. clk and rst_n stay plain ports on the module.
//
//   Producer -> queue : flush, alloc_1_vld, alloc_2_vld, entry_ready[15:0],
//                       issue_ready
//   Queue -> consumer : issue_1_vld/issue_1_addr, issue_2_vld/issue_2_addr,
//                       head_ptr, tail_ptr, count[4:0], full, empty, overflow
//
//   modport slave  : the queue block itself
//   modport master : whatever drives allocations / accepts issues
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface ins_issue_read_if;
  logic        flush;
  logic        alloc_1_vld;
  logic        alloc_2_vld;
  logic [15:0] entry_ready;
  logic        issue_ready;

  logic        issue_1_vld;
  logic [3:0]  issue_1_addr;
  logic        issue_2_vld;
  logic [3:0]  issue_2_addr;
  logic [3:0]  head_ptr;
  logic [3:0]  tail_ptr;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;

  modport master (
    output flush, alloc_1_vld, alloc_2_vld, entry_ready, issue_ready,
    input  issue_1_vld, issue_1_addr, issue_2_vld, issue_2_addr,
    input  head_ptr, tail_ptr, count, full, empty, overflow
  );

  modport slave (
    input  flush, alloc_1_vld, alloc_2_vld, entry_ready, issue_ready,
    output issue_1_vld, issue_1_addr, issue_2_vld, issue_2_addr,
    output head_ptr, tail_ptr, count, full, empty, overflow
  );
endinterface

// File: rtl/ins_issue_read.sv
// ---------------------------------------------------------------------------
// ins_issue_read
//   Read/retire end of a 16-entry circular instruction queue. Tracks the
//   head (oldest occupied), tail (next free) and occupancy, and presents up
//   to two of the oldest ready entries per cycle, strictly in age order.
//
// Ports
//   clk    : single clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ins_issue_read_if.slave
//     flush            synchronous clear of pointers, count and issue slots
//     alloc_1_vld      one entry written at tail this cycle
//     alloc_2_vld      second entry at tail+1 (ignored without alloc_1_vld)
//     entry_ready      per-address ready-to-issue bits
//     issue_ready      consumer takes both output slots this cycle
//     issue_N_vld/addr output slots (addr is 15 when the slot is invalid)
//     head_ptr/tail_ptr, count (0..16), full, empty
//     overflow         sticky: an allocation was dropped for lack of space
//
// Behaviour notes
//   - Entries sitting in the output slots remain counted until they retire;
//     a retire removes every held entry at once (both slots go together).
//   - The allocation space check uses the count from before this cycle, so
//     a retire in the same cycle does not make room for a new allocation.
//   - Slots reload whenever they are empty or being retired. The first
//     candidate is the first entry not already held; only entries counted
//     before this cycle are candidates, so fresh allocations wait a cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ins_issue_read (
  input  logic            clk,
  input  logic            rst_n,
  ins_issue_read_if.slave bus
);

  localparam logic [3:0] ADDR_NONE = 4'd15;
  localparam logic [5:0] DEPTH     = 6'd16;

  // ---------------------------------------------------------------- state
  logic [3:0] head_reg,       head_next;
  logic [3:0] tail_reg,       tail_next;
  logic [4:0] count_reg,      count_next;
  logic       slot1_vld_reg,  slot1_vld_next;
  logic [3:0] slot1_addr_reg, slot1_addr_next;
  logic       slot2_vld_reg,  slot2_vld_next;
  logic [3:0] slot2_addr_reg, slot2_addr_next;
  logic       overflow_reg,   overflow_next;

  // --------------------------------------------------------- datapath nets
  logic [1:0] n_alloc;
  logic [5:0] alloc_total;
  logic       alloc_ok;
  logic [4:0] alloc_inc;
  logic [1:0] held;
  logic       retire;
  logic [1:0] n_retire;
  logic       load;
  logic [3:0] base;
  logic [4:0] avail;
  logic [3:0] cand_addr  [2];
  logic [1:0] cand_ready;
  logic       slot1_load;
  logic       slot2_load;

  // alloc_2_vld on its own carries no entry.
  assign n_alloc = bus.alloc_1_vld ? (bus.alloc_2_vld ? 2'd2 : 2'd1) : 2'd0;

  // Space check against the pre-cycle count; a zero-size request always fits.
  assign alloc_total = {1'b0, count_reg} + {4'b0000, n_alloc};
  assign alloc_ok    = (alloc_total <= DEPTH);
  assign alloc_inc   = alloc_ok ? {3'b000, n_alloc} : 5'd0;

  assign held     = {1'b0, slot1_vld_reg} + {1'b0, slot2_vld_reg};
  assign retire   = slot1_vld_reg & bus.issue_ready;
  assign n_retire = retire ? held : 2'd0;
  assign load     = (held == 2'd0) | retire;

  // First entry not currently held. After a retire the new head equals this
  // same address, so one expression covers both the idle and retire cases.
  assign base  = head_reg + {2'b00, held};
  assign avail = count_reg - {3'b000, held};

  // Two consecutive candidate addresses starting at base, wrapping mod 16.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cand
    assign cand_addr[gi]  = base + 4'(gi);
    assign cand_ready[gi] = bus.entry_ready[cand_addr[gi]];
  end

  // In-order selection: slot 2 only ever follows a valid slot 1.
  assign slot1_load = (avail >= 5'd1) & cand_ready[0];
  assign slot2_load = slot1_load & (avail >= 5'd2) & cand_ready[1];

  // ------------------------------------------------------ next-state logic
  always_comb begin
    head_next       = head_reg;
    tail_next       = tail_reg;
    count_next      = count_reg;
    slot1_vld_next  = slot1_vld_reg;
    slot1_addr_next = slot1_addr_reg;
    slot2_vld_next  = slot2_vld_reg;
    slot2_addr_next = slot2_addr_reg;
    overflow_next   = overflow_reg;

    if (bus.flush) begin
      // Flush wins over allocation and retirement; overflow is left alone.
      head_next       = 4'd0;
      tail_next       = 4'd0;
      count_next      = 5'd0;
      slot1_vld_next  = 1'b0;
      slot1_addr_next = ADDR_NONE;
      slot2_vld_next  = 1'b0;
      slot2_addr_next = ADDR_NONE;
    end else begin
      head_next = head_reg + {2'b00, n_retire};

      if (alloc_ok) begin
        tail_next = tail_reg + {2'b00, n_alloc};
      end else begin
        // Whole request dropped; remember it until reset.
        overflow_next = 1'b1;
      end

      count_next = count_reg + alloc_inc - {3'b000, n_retire};

      if (load) begin
        slot1_vld_next  = slot1_load;
        slot1_addr_next = slot1_load ? cand_addr[0] : ADDR_NONE;
        slot2_vld_next  = slot2_load;
        slot2_addr_next = slot2_load ? cand_addr[1] : ADDR_NONE;
      end
    end
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg       <= 4'd0;
      tail_reg       <= 4'd0;
      count_reg      <= 5'd0;
      slot1_vld_reg  <= 1'b0;
      slot1_addr_reg <= ADDR_NONE;
      slot2_vld_reg  <= 1'b0;
      slot2_addr_reg <= ADDR_NONE;
      overflow_reg   <= 1'b0;
    end else begin
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      slot1_vld_reg  <= slot1_vld_next;
      slot1_addr_reg <= slot1_addr_next;
      slot2_vld_reg  <= slot2_vld_next;
      slot2_addr_reg <= slot2_addr_next;
      overflow_reg   <= overflow_next;
    end
  end

  // --------------------------------------------------------------- outputs
  assign bus.issue_1_vld  = slot1_vld_reg;
  assign bus.issue_1_addr = slot1_addr_reg;
  assign bus.issue_2_vld  = slot2_vld_reg;
  assign bus.issue_2_addr = slot2_addr_reg;
  assign bus.head_ptr     = head_reg;
  assign bus.tail_ptr     = tail_reg;
  assign bus.count        = count_reg;
  assign bus.full         = (count_reg == 5'd16);
  assign bus.empty        = (count_reg == 5'd0);
  assign bus.overflow     = overflow_reg;

endmodule

// File: tb/tb_ins_issue_read.sv
// ---------------------------------------------------------------------------
// tb_ins_issue_read
//   Scoreboard bench for ins_issue_read. The driver applies one set of
//   inputs per cycle (2 ns after the rising edge) and advances a reference
//   model built on monotonic alloc/retire counters and an age-ordered scan.
//   It pushes the expected status for every cycle and one record per issue
//   load; the monitor samples on the falling edge, compares status, and
//   pops an issue record whenever the DUT hands over its slots.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ins_issue_read;

  localparam logic [15:0] ALL = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ins_issue_read_if bus ();

  ins_issue_read dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int head; int tail; int count; int full; int empty; int ovf;
    int v1; int a1; int v2; int a2;
  } stat_t;

  typedef struct {
    int a1; int v2; int a2;
  } iss_t;

  stat_t stat_q[$];
  iss_t  iss_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: total allocated / total retired, plus held slots
  int m_head, m_tail, m_held, m_slot0, m_slot1;
  bit m_ovf;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_head = 0; m_tail = 0; m_held = 0;
    m_slot0 = 15; m_slot1 = 15; m_ovf = 1'b0;
  endfunction

  function automatic stat_t model_status();
    stat_t s;
    int cnt;
    cnt     = m_tail - m_head;
    s.head  = m_head % 16;
    s.tail  = m_tail % 16;
    s.count = cnt;
    s.full  = (cnt == 16) ? 1 : 0;
    s.empty = (cnt == 0) ? 1 : 0;
    s.ovf   = m_ovf ? 1 : 0;
    s.v1    = (m_held >= 1) ? 1 : 0;
    s.a1    = (m_held >= 1) ? m_slot0 : 15;
    s.v2    = (m_held == 2) ? 1 : 0;
    s.a2    = (m_held == 2) ? m_slot1 : 15;
    return s;
  endfunction

  function automatic void model_step(bit a1, bit a2, logic [15:0] rdy, bit ir, bit fl);
    int  n, cnt, first, avail, k, ns0, ns1;
    bit  ret;
    n   = a1 ? (a2 ? 2 : 1) : 0;
    cnt = m_tail - m_head;
    if (fl) begin
      // held slots vanish without a handover
      if (m_held > 0 && iss_q.size() > 0) iss_q.delete(0);
      m_head = 0; m_tail = 0; m_held = 0; m_slot0 = 15; m_slot1 = 15;
      return;
    end
    ret = (m_held > 0) && ir;
    if (m_held == 0 || ret) begin
      first = m_head + m_held;
      avail = cnt - m_held;
      k = 0; ns0 = 15; ns1 = 15;
      while (k < 2 && k < avail && rdy[(first + k) % 16]) begin
        if (k == 0) ns0 = (first + k) % 16;
        else        ns1 = (first + k) % 16;
        k++;
      end
      if (ret) m_head = m_head + m_held;
      m_held = k; m_slot0 = ns0; m_slot1 = ns1;
      if (k > 0) iss_q.push_back('{ns0, (k == 2) ? 1 : 0, ns1});
    end
    if (cnt + n <= 16) m_tail = m_tail + n;
    else               m_ovf  = 1'b1;
  endfunction

  task automatic cyc(input bit a1, input bit a2, input logic [15:0] rdy,
                     input bit ir, input bit fl);
    @(posedge clk);
    #2;
    stat_q.push_back(model_status());
    bus.alloc_1_vld = a1;
    bus.alloc_2_vld = a2;
    bus.entry_ready = rdy;
    bus.issue_ready = ir;
    bus.flush       = fl;
    model_step(a1, a2, rdy, ir, fl);
  endtask

  task automatic idle_inputs();
    bus.alloc_1_vld = 1'b0;
    bus.alloc_2_vld = 1'b0;
    bus.entry_ready = 16'h0000;
    bus.issue_ready = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_head"},  int'(bus.head_ptr),     0);
    check({tag, "_tail"},  int'(bus.tail_ptr),     0);
    check({tag, "_count"}, int'(bus.count),        0);
    check({tag, "_v1"},    int'(bus.issue_1_vld),  0);
    check({tag, "_v2"},    int'(bus.issue_2_vld),  0);
    check({tag, "_a1"},    int'(bus.issue_1_addr), 15);
    check({tag, "_a2"},    int'(bus.issue_2_addr), 15);
    check({tag, "_ovf"},   int'(bus.overflow),     0);
    check({tag, "_empty"}, int'(bus.empty),        1);
    check({tag, "_full"},  int'(bus.full),         0);
  endtask

  // Reset pulse placed between edges; outputs must clear immediately.
  task automatic async_reset_mid();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    stat_q.delete();
    iss_q.delete();
    model_reset();
    check_reset_values("async_rst");
    idle_inputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------- monitor
  initial begin : monitor
    stat_t s;
    iss_t  r;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check("head_ptr",     int'(bus.head_ptr),     s.head);
        check("tail_ptr",     int'(bus.tail_ptr),     s.tail);
        check("count",        int'(bus.count),        s.count);
        check("full",         int'(bus.full),         s.full);
        check("empty",        int'(bus.empty),        s.empty);
        check("overflow",     int'(bus.overflow),     s.ovf);
        check("issue_1_vld",  int'(bus.issue_1_vld),  s.v1);
        check("issue_1_addr", int'(bus.issue_1_addr), s.a1);
        check("issue_2_vld",  int'(bus.issue_2_vld),  s.v2);
        check("issue_2_addr", int'(bus.issue_2_addr), s.a2);
      end
      if (rst_n && bus.issue_1_vld && bus.issue_ready && !bus.flush) begin
        if (iss_q.size() == 0) begin
          check("issue_unexpected", 1, 0);
        end else begin
          r = iss_q.pop_front();
          $display("xfer t=%0t a1=%0d v2=%0d a2=%0d", $time,
                   bus.issue_1_addr, bus.issue_2_vld, bus.issue_2_addr);
          check("xfer_a1", int'(bus.issue_1_addr), r.a1);
          check("xfer_v2", int'(bus.issue_2_vld),  r.v2);
          check("xfer_a2", int'(bus.issue_2_addr), r.a2);
        end
      end
    end
  end

  // -------------------------------------------------------------- driver
  initial begin : driver
    bit          ra1, ra2, rir, rfl;
    logic [15:0] rrdy;

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    rst_n = 1'b1;

    // two entries issued together then retired
    cyc(1, 1, ALL, 1, 0);
    cyc(0, 0, ALL, 1, 0);
    cyc(0, 0, ALL, 1, 0);
    check("r22_v1", int'(bus.issue_1_vld), 1);
    check("r22_a1", int'(bus.issue_1_addr), 0);
    check("r22_v2", int'(bus.issue_2_vld), 1);
    check("r22_a2", int'(bus.issue_2_addr), 1);
    cyc(0, 0, ALL, 0, 0);
    check("r22_count", int'(bus.count), 0);
    check("r22_head",  int'(bus.head_ptr), 2);
    check("r22_empty", int'(bus.empty), 1);

    // fill to 16, then one extra allocation is dropped
    cyc(0, 0, 16'h0000, 0, 1);
    repeat (8) cyc(1, 1, 16'h0000, 0, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    cyc(0, 0, ALL, 0, 0);
    check("r23_full",  int'(bus.full), 1);
    check("r23_count", int'(bus.count), 16);
    check("r23_tail",  int'(bus.tail_ptr), 0);
    check("r23_ovf",   int'(bus.overflow), 1);

    // slots loaded then held for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, ALL, 0, 0);
      check("r26_hold_a1", int'(bus.issue_1_addr), 0);
      check("r26_hold_a2", int'(bus.issue_2_addr), 1);
      check("r26_hold_cnt", int'(bus.count), 16);
    end
    // retire two while allocating two at count 16: allocation rejected
    cyc(1, 1, ALL, 1, 0);
    cyc(0, 0, 16'h0000, 0, 0);
    check("r26_count", int'(bus.count), 14);

    // bring head to 15, then issue across the wrap
    cyc(0, 0, 16'h0000, 0, 1);
    repeat (7) cyc(1, 1, 16'h0000, 0, 0);
    cyc(1, 0, 16'h0000, 0, 0);
    repeat (10) cyc(0, 0, ALL, 1, 0);
    cyc(1, 1, 16'h0000, 1, 0);
    cyc(0, 0, 16'h8001, 0, 0);
    cyc(0, 0, 16'h8001, 1, 0);
    check("r24_a1", int'(bus.issue_1_addr), 15);
    check("r24_a2", int'(bus.issue_2_addr), 0);
    cyc(0, 0, 16'h0000, 0, 0);
    check("r24_head", int'(bus.head_ptr), 1);

    // head not ready blocks the younger ready entry
    cyc(1, 1, 16'h0000, 0, 0);
    repeat (3) cyc(0, 0, 16'h0004, 1, 0);
    check("r25_blocked", int'(bus.issue_1_vld), 0);
    cyc(0, 0, 16'h0006, 1, 0);
    cyc(0, 0, 16'h0006, 0, 0);
    check("r25_a1", int'(bus.issue_1_addr), 1);
    check("r25_a2", int'(bus.issue_2_addr), 2);

    // flush with allocation and pending issue in the same cycle
    cyc(1, 1, ALL, 1, 1);
    cyc(0, 0, 16'h0000, 0, 0);
    check("r27_count", int'(bus.count), 0);
    check("r27_head",  int'(bus.head_ptr), 0);
    check("r27_tail",  int'(bus.tail_ptr), 0);
    check("r27_v1",    int'(bus.issue_1_vld), 0);
    check("r27_ovf",   int'(bus.overflow), 1);

    // randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset_mid();
      ra1  = ($urandom_range(0, 99) < 55);
      ra2  = $urandom_range(0, 1) == 1;
      rrdy = ($urandom_range(0, 3) == 0) ? ALL : 16'($urandom);
      rir  = ($urandom_range(0, 99) < 60);
      rfl  = ($urandom_range(0, 59) == 0);
      cyc(ra1, ra2, rrdy, rir, rfl);
    end

    // drain whatever is held
    repeat (5) cyc(0, 0, 16'h0000, 1, 0);
    @(negedge clk);
    #1;
    check("issue_q_drained", iss_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ins_issue_read.md
INS_ISSUE_READ -- requirements
Module: ins_issue_read

Purpose: read/retire end of the 16-entry circular instruction queue; tracks head/tail/occupancy, issues up to two oldest ready entries per cycle in order.

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous queue clear
- alloc_1_vld  in  1  one new entry written at tail this cycle
- alloc_2_vld  in  1  second new entry written at tail+1; valid only with alloc_1_vld
- entry_ready  in  16  per-entry ready-to-issue bit, indexed by queue address
- issue_ready  in  1  downstream accepts both output slots this cycle
- issue_1_vld / issue_1_addr  out  1 / 4  oldest issued entry
- issue_2_vld / issue_2_addr  out  1 / 4  next-oldest issued entry
- head_ptr, tail_ptr  out  4 / 4  oldest occupied address; next free address
- count  out  5  occupied entries, 0..16
- full, empty  out  1 / 1  count==16; count==0
- overflow  out  1  sticky: allocation dropped for lack of space
REQ-002 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-003 SHALL use 4-bit head_ptr/tail_ptr, wrapping 15->0 modulo 16.
REQ-004 n_alloc SHALL be 2 (both valids), 1 (alloc_1_vld only), else 0; alloc_2_vld alone SHALL be ignored.
REQ-005 Allocation SHALL be accepted only if count + n_alloc <= 16, using the pre-cycle count; on acceptance tail_ptr += n_alloc.
REQ-006 A rejected allocation SHALL drop both entries, leave tail_ptr unchanged and set overflow until reset.
REQ-007 held = issue_1_vld + issue_2_vld; entries in output slots SHALL stay counted until retired.
REQ-008 Handshake: retire when issue_1_vld && issue_ready; n_retire = held; head_ptr += n_retire.
REQ-009 count_next SHALL be count + accepted n_alloc - n_retire in the same cycle.
REQ-010 Output slots SHALL load when held==0 or retire occurs; otherwise hold all values stable.
REQ-011 Load: base = head_ptr + (held if no retire, else held) mod 16, i.e. first non-held entry; avail = count - held.
REQ-012 Slot 1 SHALL load valid with addr=base iff avail>=1 and entry_ready[base].
REQ-013 Slot 2 SHALL load valid with addr=base+1 (mod 16) iff slot 1 loads valid, avail>=2 and entry_ready[base+1]; strict in-order, no skipping.
REQ-014 issue_2_vld SHALL never be 1 while issue_1_vld is 0.
REQ-015 Entries allocated in the current cycle SHALL NOT be issue candidates until the next cycle.
REQ-016 Issue latency: entry ready at head with empty slots -> issue_1_vld on the next clock edge.
REQ-017 flush SHALL, next edge: head_ptr=tail_ptr=0, count=0, issue valids=0, addrs=15; flush overrides alloc and retire same cycle; overflow unaffected.
REQ-018 Invalid slots SHALL drive addr=15.
REQ-019 full/empty SHALL be combinational from registered count.

Reset
REQ-020 On rst_n low, asynchronously: head_ptr=0, tail_ptr=0, count=0, issue_1_vld=issue_2_vld=0, issue_1_addr=issue_2_addr=15, overflow=0; empty=1, full=0.
REQ-021 Reset asserted mid-operation SHALL discard all held issues with no retire; first edge after deassertion behaves as post-reset idle.

Verification
REQ-022 Reset, alloc 2 (entries 0,1), entry_ready=all 1, issue_ready=1 -> next cycle slots 0/1 valid; following cycle count=0, head_ptr=2, empty=1.
REQ-023 Fill 16 (8 dual allocs), no ready -> full=1, count=16; extra alloc_1_vld -> tail_ptr=0 unchanged, overflow=1.
REQ-024 head_ptr=15, count=2, ready[15]=ready[0]=1 -> issue_1_addr=15, issue_2_addr=0; after retire head_ptr=1.
REQ-025 entry_ready[head]=0, ready[head+1]=1 -> no issue; after ready[head] rises, both slots issue next cycle.
REQ-026 issue_ready=0 for 3 cycles with slots valid -> addrs/valids stable, count unchanged; alloc 2 in same cycle as retire of 2 at count=16 -> alloc rejected, count=14.
REQ-027 flush with alloc_2 and pending issue same cycle -> count=0, head_ptr=tail_ptr=0, valids=0; rst_n pulse mid-stream -> all outputs at REQ-020 values immediately.
